ps2_key_decoder: RTL and testbench

- Sits between PS2_receiver and the game logic in top.
- Turns the raw set-2 scan-code byte stream into held-key levels for Up/Right/Down/Left and a single-cycle bomb-drop pulse.
- Tracks the E0 (extended) and F0 (break) prefixes with a small FSM, and uses a timeout so a lost byte cannot leave a key stuck.
- Outputs feed top's current-direction next-state logic and bomb_module directly.

---
 rtl/ps2_key_decoder.sv | 139 +++++++++++++
 tb/tb_ps2_key_decoder.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 scan-code decoder: tracks the E0/F0 prefixes and turns the byte
// stream into held direction levels, a space-held flag and a bomb-drop pulse.
// A timeout drops a half-received prefix sequence so a lost byte cannot wedge
// the decoder.
module ps2_key_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 250000,
  parameter bit          ENABLE_WASD    = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       key_u,
  output logic       key_r,
  output logic       key_d,
  output logic       key_l,
  output logic       bomb_pulse,
  output logic       key_any
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } state_t;

  // Held flags are packed as {U, R, D, L}.
  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [3:0]      r_arrow;
  logic [3:0]      r_wasd;
  logic            r_space;

  state_t          w_state_nx;
  logic [3:0]      w_arrow_nx;
  logic [3:0]      w_wasd_nx;
  logic            w_space_nx;
  logic            w_bomb_nx;
  logic            w_is_e0;
  logic            w_is_f0;
  logic            w_ext;
  logic            w_brk;
  logic            w_final;
  logic            w_make;

  // Decode the incoming byte against the current prefix state and derive the
  // next flag values. A byte arriving in the timeout cycle is handled from
  // the current state, so the timeout only applies in idle cycles.
  always_comb begin
    w_is_e0    = (rx_data == 8'hE0);
    w_is_f0    = (rx_data == 8'hF0);
    w_ext      = (r_state == EXT) || (r_state == EXT_BRK);
    w_brk      = (r_state == BRK) || (r_state == EXT_BRK);
    w_final    = rx_valid && !w_is_e0 && !w_is_f0;
    w_make     = !w_brk;
    w_state_nx = r_state;
    w_arrow_nx = r_arrow;
    w_wasd_nx  = r_wasd;
    w_space_nx = r_space;
    w_bomb_nx  = 1'b0;

    if (rx_valid) begin
      unique case (r_state)
        IDLE:    w_state_nx = w_is_e0 ? EXT : (w_is_f0 ? BRK : IDLE);
        EXT:     w_state_nx = w_is_f0 ? EXT_BRK : (w_is_e0 ? EXT : IDLE);
        BRK:     w_state_nx = w_is_e0 ? EXT_BRK : (w_is_f0 ? BRK : IDLE);
        EXT_BRK: w_state_nx = (w_is_e0 || w_is_f0) ? EXT_BRK : IDLE;
        default: w_state_nx = IDLE;
      endcase
    end else if (r_state != IDLE && r_cnt == TMAX) begin
      w_state_nx = IDLE;
    end

    if (w_final) begin
      if (w_ext) begin
        case (rx_data)
          8'h75:   w_arrow_nx[3] = w_make;
          8'h74:   w_arrow_nx[2] = w_make;
          8'h72:   w_arrow_nx[1] = w_make;
          8'h6B:   w_arrow_nx[0] = w_make;
          default: ;
        endcase
      end else begin
        case (rx_data)
          8'h1D:   if (ENABLE_WASD) w_wasd_nx[3] = w_make;
          8'h23:   if (ENABLE_WASD) w_wasd_nx[2] = w_make;
          8'h1B:   if (ENABLE_WASD) w_wasd_nx[1] = w_make;
          8'h1C:   if (ENABLE_WASD) w_wasd_nx[0] = w_make;
          8'h29: begin
            w_space_nx = w_make;
            w_bomb_nx  = w_make && !r_space;
          end
          default: ;
        endcase
      end
    end
  end

  // Register state, flags, timeout counter and the outputs together so the
  // outputs follow the final byte of a sequence by exactly one clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_arrow    <= '0;
      r_wasd     <= '0;
      r_space    <= 1'b0;
      key_u      <= 1'b0;
      key_r      <= 1'b0;
      key_d      <= 1'b0;
      key_l      <= 1'b0;
      bomb_pulse <= 1'b0;
      key_any    <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_arrow <= w_arrow_nx;
      r_wasd  <= w_wasd_nx;
      r_space <= w_space_nx;

      if (rx_valid) begin
        r_cnt <= '0;
      end else if (r_state != IDLE && r_cnt != TMAX) begin
        r_cnt <= r_cnt + CW'(1);
      end

      key_u      <= w_arrow_nx[3] | w_wasd_nx[3];
      key_r      <= w_arrow_nx[2] | w_wasd_nx[2];
      key_d      <= w_arrow_nx[1] | w_wasd_nx[1];
      key_l      <= w_arrow_nx[0] | w_wasd_nx[0];
      bomb_pulse <= w_bomb_nx;
      key_any    <= (|(w_arrow_nx | w_wasd_nx)) | w_space_nx;
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: two instances (WASD on / off) share the
// stimulus; expected output vectors are queued per step and compared one clock
// after each byte or idle cycle.
module tb_ps2_key_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0;

  logic u1, r1, d1, l1, b1, a1;
  logic u2, r2, d2, l2, b2, a2;

  typedef struct {
    string      tag;
    logic [6:0] exp;   // {u, r, d, l, bomb, any, u_of_wasd_disabled_dut}
  } exp_t;

  exp_t q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  ps2_key_decoder #(.TIMEOUT_CYCLES(16), .ENABLE_WASD(1'b1)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .key_u(u1), .key_r(r1), .key_d(d1), .key_l(l1),
    .bomb_pulse(b1), .key_any(a1)
  );

  ps2_key_decoder #(.TIMEOUT_CYCLES(16), .ENABLE_WASD(1'b0)) dut_nowasd (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .key_u(u2), .key_r(r2), .key_d(d2), .key_l(l2),
    .bomb_pulse(b2), .key_any(a2)
  );

  task automatic expect_out(input string tag, input logic [6:0] e);
    exp_t x;
    x.tag = tag;
    x.exp = e;
    q.push_back(x);
  endtask

  task automatic check_out();
    exp_t       x;
    logic [6:0] obs;
    obs = {u1, r1, d1, l1, b1, a1, u2};
    n_total++;
    if (q.size() == 0) begin
      $error("FAIL scoreboard_empty observed=%b expected=<entry>", obs);
    end else begin
      x = q.pop_front();
      assert (obs === x.exp) n_pass++;
      else $error("FAIL %s observed=%b expected=%b", x.tag, obs, x.exp);
    end
  endtask

  // Drive one byte for a single clock, then compare one clock later.
  task automatic send(input logic [7:0] b, input string tag, input logic [6:0] e);
    expect_out(tag, e);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    check_out();
  endtask

  task automatic idle_chk(input string tag, input logic [6:0] e);
    expect_out(tag, e);
    @(posedge clk);
    #1;
    check_out();
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    // Reset held: a WASD byte must not register.
    rst = 1'b0;
    idle(2);
    idle_chk("reset_state", 7'b0000000);
    send(8'h1D, "byte_in_reset", 7'b0000000);
    rst = 1'b1;
    idle(1);

    // Arrow up via the extended path; both instances see arrows.
    send(8'hE0, "up_prefix",  7'b0000000);
    send(8'h75, "up_make",    7'b1000011);
    send(8'hE0, "left_pre",   7'b1000011);
    send(8'h6B, "left_make",  7'b1001011);
    send(8'hE0, "lbrk_e0",    7'b1001011);
    send(8'hF0, "lbrk_f0",    7'b1001011);
    send(8'h6B, "left_break", 7'b1000011);
    send(8'hE0, "left_pre2",  7'b1000011);
    send(8'h6B, "left_make2", 7'b1001011);
    send(8'hF0, "nx_brk_f0",  7'b1001011);
    send(8'h6B, "nonext_brk", 7'b1001011);
    send(8'hE0, "clr_e0a",    7'b1001011);
    send(8'hF0, "clr_f0a",    7'b1001011);
    send(8'h6B, "clr_left",   7'b1000011);
    send(8'hE0, "clr_e0b",    7'b1000011);
    send(8'hF0, "clr_f0b",    7'b1000011);
    send(8'h75, "clr_up",     7'b0000000);

    // Space typematic: only fresh makes pulse.
    send(8'h29, "space_make1",  7'b0000110);
    idle_chk("space_pulse_end", 7'b0000010);
    send(8'h29, "space_rep1",   7'b0000010);
    send(8'h29, "space_rep2",   7'b0000010);
    send(8'hF0, "space_brk_f0", 7'b0000010);
    send(8'h29, "space_break",  7'b0000000);
    send(8'h29, "space_make2",  7'b0000110);
    idle_chk("space_pulse_end2", 7'b0000010);
    send(8'hF0, "space_brk2_f0", 7'b0000010);
    send(8'h29, "space_break2",  7'b0000000);

    // W and arrow-up overlap; WASD-disabled instance ignores W.
    send(8'h1D, "w_make",     7'b1000010);
    send(8'hE0, "ovl_e0",     7'b1000010);
    send(8'h75, "ovl_up",     7'b1000011);
    send(8'hF0, "w_brk_f0",   7'b1000011);
    send(8'h1D, "w_break",    7'b1000011);
    send(8'hE0, "up_brk_e0",  7'b1000011);
    send(8'hF0, "up_brk_f0",  7'b1000011);
    send(8'h75, "up_break",   7'b0000000);

    // Timeout: one idle cycle past the saturation point abandons the prefix.
    send(8'hE0, "to_e0a",     7'b0000000);
    idle(20);
    send(8'h74, "to_dropped", 7'b0000000);
    send(8'hE0, "to_e0b",     7'b0000000);
    idle(17);
    send(8'h74, "to_edge_dropped", 7'b0000000);
    // Byte arriving in the cycle the timeout would fire is still extended.
    send(8'hE0, "to_e0c",     7'b0000000);
    idle(16);
    send(8'h74, "to_edge_wins", 7'b0100010);
    send(8'hE0, "rbrk_e0",    7'b0100010);
    send(8'hF0, "rbrk_f0",    7'b0100010);
    send(8'h74, "r_break",    7'b0000000);
    send(8'hE0, "to_e0d",     7'b0000000);
    idle(10);
    send(8'h74, "to_in_time", 7'b0100010);

    // Unknown extended break: no change, decoder back in IDLE.
    send(8'hE0, "unk_e0",     7'b0100010);
    send(8'hF0, "unk_f0",     7'b0100010);
    send(8'h55, "unk_code",   7'b0100010);
    send(8'h1B, "s_make",     7'b0110010);

    // Reset in the middle of a break sequence.
    send(8'hE0, "mid_e0",     7'b0110010);
    send(8'hF0, "mid_f0",     7'b0110010);
    #2;
    rst = 1'b0;
    #1;
    expect_out("async_reset", 7'b0000000);
    check_out();
    idle(1);
    rst = 1'b1;
    idle(1);
    send(8'h1D, "post_rst_idle", 7'b1000010);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
